// File: rtl/serial_adder.sv
// Bit-serial adder: {c_out, s} = a + b + c_in computed by one full-adder cell over WIDTH clocks.
// Valid/ready handshake on both sides; one operation in flight at a time.
module serial_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   s_sr_q, s_sr_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_out_q, c_out_d;
    logic               out_valid_q, out_valid_d;

    logic               sum_bit;
    logic               carry_nxt;
    logic [WIDTH-1:0]   s_shift;

    // Single full-adder cell working on the operand LSBs.
    always_comb begin
        sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
        s_shift   = s_sr_q >> 1;
        s_shift[WIDTH-1] = sum_bit;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        s_sr_d      = s_sr_q;
        carry_d     = carry_q;
        s_d         = s_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = c_in;
                    s_sr_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                s_sr_d  = s_shift;
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    s_d         = s_shift;
                    c_out_d     = carry_nxt;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            s_sr_q      <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            s_sr_q      <= s_sr_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ready is gated by reset so nothing is accepted while the block is being cleared.
    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign c_out     = c_out_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial counterpart to the parallel ripple adder: same arithmetic result, {c_out,s} = a + b + c_in, computed by one full-adder cell iterated over WIDTH clocks.
- Sits in front of the result checker and has valid/ready on both sides, so it can be dropped into a stream.
- Used where area beats latency, and as a sequential golden model alongside the combinational ripple adder.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  a, b, c_in are valid this cycle.
- in_ready  output  1  block can accept an operand pair this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  s/c_out hold a completed result.
- out_ready  input  1  downstream consumes the result this cycle.
- s  output  WIDTH  sum bits [WIDTH-1:0].
- c_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state goes to IDLE; bit counter, shift registers and carry go to 0.
  - out_valid=0, s=0, c_out=0.
  - in_ready is forced to 0 while rst_n is low.
  - Reset mid-RUN or mid-DONE abandons the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: load A and B shift registers, load carry<=c_in, clear counter to 0, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: full-add the LSBs of A, B and carry.
  - Shift the sum bit into the MSB of the S shift register (right shift). Shift A and B right, update carry, increment counter.
  - On the edge where counter==WIDTH-1: go to DONE and set out_valid<=1. c_out takes the final carry; s takes the full WIDTH bits.
- DONE:
  - in_ready=0; s and c_out held stable while out_valid=1.
  - On out_ready: out_valid<=0, go to IDLE.
  - out_ready while out_valid=0 is ignored.
- Latency:
  - Accept at edge k; out_valid high after edge k+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles (1 accept, WIDTH run, 1 drain).
  - Back-to-back overlap is not supported.
- Arithmetic:
  - Unsigned modulo 2^(WIDTH+1).
  - Maximum is (2^WIDTH-1)*2+1, with c_out=1 and s all ones.
- Counter width is $clog2(WIDTH)+1. WIDTH=1 must work: one RUN cycle.
- Inputs a/b/c_in are don't-care outside the accepting cycle. Changes during RUN must not affect the result.
- in_valid held high in RUN or DONE is not accepted. It is accepted in the first IDLE cycle after the handshake completes.
- Output regs s/c_out keep their last value after out_valid drops. The bench must check them only while out_valid=1.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles -> in_ready=0, out_valid=0, s=0, c_out=0. After release, in_ready=1 next cycle.
- Basic add, WIDTH=4: a=3, b=5, c_in=0 accepted at edge k -> out_valid rises after edge k+4 with s=8, c_out=0. out_ready=1 -> IDLE, in_ready=1.
- Carry chain: a=15, b=1, c_in=0 -> {c_out,s}=16 (c_out=1, s=0). a=15, b=15, c_in=1 -> c_out=1, s=15.
- Backpressure: a=9, b=9 with out_ready=0 for 10 cycles -> out_valid stays 1, s=2, c_out=1 stable. in_ready=0 throughout; a new in_valid is not accepted until after out_ready.
- Reset mid-operation: accept a=7, b=6, assert rst_n=0 at RUN cycle 2 -> no out_valid. After release, a fresh a=1, b=1 gives s=2, c_out=0.
- Random: 100 transactions of $urandom_range(15,0) operands with random c_in and random out_ready stalls -> every result matches a+b+c_in in 5 bits. Also run WIDTH=1 and WIDTH=8 builds.
